instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec FSM with a memory handshake,
// a memory-timeout error, a HALT encoding and a saturating retired-instruction counter.
module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  instr,
  input  logic        lt_flag,
  input  logic [9:0]  br_target,
  input  logic        mem_ack,
  output logic [9:0]  pc,
  output logic [8:0]  ir,
  output logic        rf_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt, StError
  } state_t;

  localparam logic [2:0] OpStr = 3'b000;
  localparam logic [2:0] OpLdr = 3'b001;
  localparam logic [2:0] OpBlt = 3'b101;
  localparam logic [8:0] HaltEnc = 9'h1FF;

  state_t      state_q, state_d;
  logic [9:0]  pc_d;
  logic [8:0]  ir_d;
  logic [15:0] retired_d;
  logic        err_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        retire;
  logic        clear_ret;
  logic [2:0]  opcode;
  logic [9:0]  pc_inc;

  assign opcode = ir[8:6];
  assign pc_inc = pc + 10'd1;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc;
    ir_d      = ir;
    err_d     = err;
    wcnt_d    = wcnt_q;
    retire    = 1'b0;
    clear_ret = 1'b0;
    unique case (state_q)
      StIdle, StHalt, StError: begin
        if (start) begin
          pc_d      = 10'd0;
          err_d     = 1'b0;
          clear_ret = 1'b1;
          state_d   = StFetch;
        end
      end
      StFetch: begin
        ir_d    = instr;
        state_d = StDecode;
      end
      StDecode: state_d = (ir == HaltEnc) ? StHalt : StExec;
      StExec: begin
        if (opcode == OpStr || opcode == OpLdr) begin
          wcnt_d  = 4'd0;
          state_d = StMem;
        end else if (opcode == OpBlt) begin
          pc_d    = lt_flag ? br_target : pc_inc;
          retire  = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (mem_ack) begin
          if (opcode == OpStr) begin
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (wcnt_q == 4'd15) begin
          // 16th MEM cycle without an ack
          err_d   = 1'b1;
          state_d = StError;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      StWb: begin
        pc_d    = pc_inc;
        retire  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase

    if (clear_ret) begin
      retired_d = 16'd0;
    end else if (retire && retired != 16'hFFFF) begin
      retired_d = retired + 16'd1;
    end else begin
      retired_d = retired;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pc       <= 10'd0;
      ir       <= 9'd0;
      retired  <= 16'd0;
      wcnt_q   <= 4'd0;
      err      <= 1'b0;
      rf_write <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      ir       <= ir_d;
      retired  <= retired_d;
      wcnt_q   <= wcnt_d;
      err      <= err_d;
      rf_write <= (state_d == StWb);
      mem_req  <= (state_d == StMem);
      mem_we   <= (state_d == StMem) && (ir_d[8:6] == OpStr);
      busy     <= (state_d != StIdle) && (state_d != StHalt);
      done     <= (state_d == StHalt);
    end
  end

endmodule
